// File: rtl/cfg_connection_block.sv
`default_nettype none
// ============================================================================
// Module      : cfg_connection_block
// Description : Unidirectional routing connection block with scan-loaded,
//               commit-protected configuration and per-tap register option.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_connection_block #(
   parameter int W         = 7,
   parameter int CONTROLIN = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [W-1:0]         east_in,
   input  logic [W-1:0]         west_in,
   output logic [W-1:0]         east_out,
   output logic [W-1:0]         west_out,
   output logic [CONTROLIN-1:0] control_input,
   input  logic                 cfg_en,
   input  logic                 cfg_in,
   output logic                 cfg_out,
   input  logic                 cfg_commit,
   output logic                 cfg_ready,
   output logic                 cfg_err
);

   localparam int c_SEL      = $clog2(2*W+1);
   localparam int c_FLD      = c_SEL + 1;
   localparam int c_CFG_BITS = CONTROLIN * c_FLD;
   localparam int c_CNT_W    = $clog2(c_CFG_BITS+2);
   localparam int c_PAD      = (1 << c_SEL) - 2*W;

   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_CFG_BITS);
   localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_CFG_BITS+1);

   logic [c_CFG_BITS-1:0] r_shadow;
   logic [c_CFG_BITS-1:0] r_active;
   logic [CONTROLIN-1:0]  r_tap;
   logic [c_CNT_W-1:0]    r_bit_cnt;
   logic                  r_cfg_err;
   logic [CONTROLIN-1:0]  w_cand;

   // Zero padding above the real tracks makes every out-of-range select read 0.
   logic [(1<<c_SEL)-1:0] w_tracks;
   assign w_tracks = {{c_PAD{1'b0}}, west_in, east_in};

   assign east_out  = west_in;
   assign west_out  = east_in;
   assign cfg_out   = r_shadow[c_CFG_BITS-1];
   assign cfg_ready = (r_bit_cnt == c_CNT_FULL);
   assign cfg_err   = r_cfg_err;

   for (genvar i = 0; i < CONTROLIN; i++) begin : g_tap
      logic [c_SEL-1:0] w_sel;
      logic             w_mode;
      assign w_sel            = r_active[i*c_FLD+1 +: c_SEL];
      assign w_mode           = r_active[i*c_FLD];
      assign w_cand[i]        = w_tracks[w_sel];
      assign control_input[i] = w_mode ? r_tap[i] : w_cand[i];
   end

   // Tap flops sample the selected track every cycle, independent of mode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tap <= '0;
      end else begin
         r_tap <= w_cand;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shadow  <= '0;
         r_active  <= '0;
         r_bit_cnt <= '0;
         r_cfg_err <= 1'b0;
      end else if (cfg_en && cfg_commit) begin
         r_cfg_err <= 1'b1;
      end else if (cfg_en) begin
         r_shadow <= {r_shadow[c_CFG_BITS-2:0], cfg_in};
         if (r_bit_cnt != c_CNT_SAT) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end else if (cfg_commit) begin
         if (cfg_ready) begin
            r_active <= r_shadow;
         end else begin
            r_cfg_err <= 1'b1;
         end
         r_bit_cnt <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cfg_connection_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_connection_block
// Description : Directed, table-driven self-checking bench for the block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_connection_block;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] east_in, west_in, east_out, west_out;
   logic [2:0] control_input;
   logic       cfg_en, cfg_in, cfg_out, cfg_commit, cfg_ready, cfg_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [6:0] ei;
      logic [6:0] wi;
      logic [2:0] exp;
   } vec_t;

   vec_t vecs[7];

   cfg_connection_block #(.W(7), .CONTROLIN(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .east_in       (east_in),
      .west_in       (west_in),
      .east_out      (east_out),
      .west_out      (west_out),
      .control_input (control_input),
      .cfg_en        (cfg_en),
      .cfg_in        (cfg_in),
      .cfg_out       (cfg_out),
      .cfg_commit    (cfg_commit),
      .cfg_ready     (cfg_ready),
      .cfg_err       (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      cfg_en = 1'b0; cfg_commit = 1'b0; cfg_in = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic shift_bits(input logic [31:0] data, input int n);
      for (int j = n-1; j >= 0; j--) begin
         cfg_en = 1'b1;
         cfg_in = data[j];
         tick();
      end
      cfg_en = 1'b0;
      cfg_in = 1'b0;
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   function automatic logic [14:0] frame(input logic [3:0] s0, input logic r0,
                                         input logic [3:0] s1, input logic r1,
                                         input logic [3:0] s2, input logic r2);
      return {s2, r2, s1, r1, s0, r0};
   endfunction

   initial begin
      logic [14:0] f_sel;
      logic [14:0] f_reg;
      logic [14:0] chain;

      // control_input = {0, wi[2], ei[3]} under the select-coverage frame
      vecs[0] = '{ei: 7'h08, wi: 7'h00, exp: 3'b001};
      vecs[1] = '{ei: 7'h00, wi: 7'h04, exp: 3'b010};
      vecs[2] = '{ei: 7'h7F, wi: 7'h7F, exp: 3'b011};
      vecs[3] = '{ei: 7'h77, wi: 7'h7B, exp: 3'b000};
      vecs[4] = '{ei: 7'h08, wi: 7'h04, exp: 3'b011};
      vecs[5] = '{ei: 7'h55, wi: 7'h2A, exp: 3'b000};
      vecs[6] = '{ei: 7'h2A, wi: 7'h55, exp: 3'b011};

      f_sel = frame(4'd3, 1'b0, 4'd9, 1'b0, 4'd14, 1'b0);
      f_reg = frame(4'd13, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
      chain = 15'h5A3C;
      east_in = '0; west_in = '0;

      // Reset values
      do_reset();
      east_in = 7'h55; west_in = 7'h2A;
      #1;
      check("rst_east_out", 32'(east_out), 32'h2A);
      check("rst_west_out", 32'(west_out), 32'h55);
      check("rst_ctrl", 32'(control_input), 32'h7);
      check("rst_ready", 32'(cfg_ready), 0);
      check("rst_err", 32'(cfg_err), 0);
      check("rst_cfg_out", 32'(cfg_out), 0);

      // Select coverage
      shift_bits(32'(f_sel), 15);
      check("sel_ready_full", 32'(cfg_ready), 1);
      commit();
      check("sel_ready_drop", 32'(cfg_ready), 0);
      check("sel_err", 32'(cfg_err), 0);
      for (int v = 0; v < 7; v++) begin
         east_in = vecs[v].ei; west_in = vecs[v].wi;
         #1;
         check($sformatf("sel_vec%0d", v), 32'(control_input), 32'(vecs[v].exp));
         check($sformatf("sel_pass%0d", v), 32'({east_out, west_out}), 32'({vecs[v].wi, vecs[v].ei}));
         tick();
      end
      for (int c = 0; c < 100; c++) begin
         east_in = 7'($urandom); west_in = 7'($urandom);
         #1;
         check("sel_sweep", 32'(control_input), 32'({1'b0, west_in[2], east_in[3]}));
         tick();
      end

      // Registered mode on west_in[6]
      shift_bits(32'(f_reg), 15);
      commit();
      east_in = 7'h00; west_in = 7'h00;
      tick(); tick();
      west_in = 7'h40;
      #1;
      check("reg_not_yet", 32'(control_input[0]), 0);
      tick();
      check("reg_rise", 32'(control_input[0]), 1);
      east_in = 7'h01;
      #1;
      check("reg_comb_others", 32'(control_input[2:1]), 32'h3);

      // Commit after 14 shifts must fail and keep the registered config
      east_in = 7'h00;
      shift_bits(32'(f_sel), 14);
      check("c14_not_ready", 32'(cfg_ready), 0);
      commit();
      check("c14_err", 32'(cfg_err), 1);
      west_in = 7'h00;
      #1;
      check("c14_active_kept", 32'(control_input[0]), 1);
      tick();
      check("c14_active_kept2", 32'(control_input[0]), 0);

      // Over-shift after reset
      do_reset();
      shift_bits(32'(f_sel) << 1, 16);
      check("c16_not_ready", 32'(cfg_ready), 0);
      commit();
      check("c16_err", 32'(cfg_err), 1);

      // Exact-length commit
      do_reset();
      shift_bits(32'(f_sel), 15);
      check("c15_ready", 32'(cfg_ready), 1);
      commit();
      check("c15_err", 32'(cfg_err), 0);
      check("c15_ready_drop", 32'(cfg_ready), 0);
      east_in = 7'h08; west_in = 7'h04;
      #1;
      check("c15_loaded", 32'(control_input), 32'h3);

      // Simultaneous shift and commit
      do_reset();
      shift_bits(32'(f_sel), 15);
      cfg_en = 1'b1; cfg_commit = 1'b1; cfg_in = 1'b0;
      tick();
      cfg_en = 1'b0; cfg_commit = 1'b0;
      east_in = 7'h01; west_in = 7'h00;
      #1;
      check("both_err", 32'(cfg_err), 1);
      check("both_cnt_kept", 32'(cfg_ready), 1);
      check("both_active_kept", 32'(control_input), 32'h7);
      check("both_cfg_out", 32'(cfg_out), 32'(f_sel[14]));
      commit();
      east_in = 7'h08; west_in = 7'h04;
      #1;
      check("both_shadow_kept", 32'(control_input), 32'h3);

      // Chain output
      do_reset();
      shift_bits(32'(chain), 15);
      check("chain_bit0", 32'(cfg_out), 32'(chain[14]));
      for (int j = 1; j < 15; j++) begin
         shift_bits(0, 1);
         check($sformatf("chain_bit%0d", j), 32'(cfg_out), 32'(chain[14-j]));
      end

      // Mid-load reset
      do_reset();
      shift_bits(32'(f_sel), 15);
      commit();
      east_in = 7'h08; west_in = 7'h00;
      #1;
      check("mid_loaded", 32'(control_input), 32'h1);
      shift_bits(32'h7F, 7);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check("mid_rst_sel_a", 32'(control_input), 32'h0);
      east_in = 7'h01;
      #1;
      check("mid_rst_sel_b", 32'(control_input), 32'h7);
      check("mid_rst_ready", 32'(cfg_ready), 0);
      shift_bits(32'(f_sel), 15);
      check("mid_rst_cnt_zero", 32'(cfg_ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
